// File: rtl/mac_window_accum.sv
// Accumulates windows of cfg_len unsigned terms into a saturating ACC_W-bit sum.
// Each window total is presented on a valid/ready output together with a sticky overflow flag.
module mac_window_accum #(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned ACC_W = 72,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovf_q;
    logic               out_valid_q;

    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W:0]     sum_w;
    logic [LEN_W-1:0]   len_new;
    logic [LEN_W-1:0]   cnt_inc;

    always_comb begin
        in_ext  = ACC_W'(in_data);
        sum_w   = {1'b0, acc_q} + {1'b0, in_ext};
        // A zero length would never complete, so it is promoted to a single-term window.
        len_new = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        cnt_inc = cnt_q + LEN_W'(1);
    end

    // in_ready is a function of state only; out_ready never reaches it combinationally.
    assign in_ready  = !rst && (state_q != StHold);
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        len_q <= len_new;
                        acc_q <= in_ext;
                        cnt_q <= LEN_W'(1);
                        ovf_q <= 1'b0;
                        if (len_new == LEN_W'(1)) begin
                            state_q     <= StHold;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        if (sum_w[ACC_W] || ovf_q) begin
                            acc_q <= '1;
                            ovf_q <= 1'b1;
                        end else begin
                            acc_q <= sum_w[ACC_W-1:0];
                        end
                        cnt_q <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_q     <= StHold;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // A presented result must stay put until the consumer takes it.
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ovf)));

    a_hold_no_accept: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> !in_ready);

endmodule
